// File: rtl/fetch_store_initiator.sv
// rtl/fetch_store_initiator.sv - instruction fetch engine with buffered prefetch and priority store port
// Optional misaligned-redirect halt is enabled by defining FETCH_ALIGN_CHECK_EN.
module fetch_store_initiator #(
   parameter logic [31:0] STARTING_ADDR = 32'h0100_0000,
   parameter int          FIFO_DEPTH    = 4
) (
   input  logic        clock,
   input  logic        reset_n,
   output logic [31:0] mem_address,
   output logic [31:0] mem_data_in,
   input  logic [31:0] mem_data_out,
   output logic        mem_read_write,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        st_valid,
   output logic        st_ready,
   input  logic [31:0] st_addr,
   input  logic [31:0] st_data,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_data,
   output logic [31:0] inst_pc,
   output logic        misalign_err
);
   localparam int PW = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {FETCH, STALL, STORE, HALT} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [PW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic        redir_pend_q, redir_pend_d;
   logic [31:0] redir_pc_q, redir_pc_d;
   logic        err_q, err_d;
   logic [31:0] fifo_data_q [FIFO_DEPTH];
   logic [31:0] fifo_pc_q [FIFO_DEPTH];

   logic [PW:0] occupancy;
   logic        empty, full, pop, push, redir_go, bad_tgt;
   logic [31:0] redir_raw, redir_tgt;

   assign occupancy    = wr_ptr_q - rd_ptr_q;
   assign empty        = (occupancy == '0);
   assign full         = (occupancy == (PW+1)'(FIFO_DEPTH));
   assign inst_valid   = !empty;
   assign inst_data    = fifo_data_q[rd_ptr_q[PW-1:0]];
   assign inst_pc      = fifo_pc_q[rd_ptr_q[PW-1:0]];
   assign misalign_err = err_q;

   // A redirect seen during STORE is held and takes effect in the first non-store cycle.
   assign redir_raw = redirect_valid ? redirect_pc : redir_pc_q;
   assign redir_go  = ((state_q == FETCH) || (state_q == STALL)) && (redirect_valid || redir_pend_q);
`ifdef FETCH_ALIGN_CHECK_EN
   assign redir_tgt = redir_raw;
   assign bad_tgt   = |redir_raw[1:0];
`else
   assign redir_tgt = redir_raw & 32'hFFFF_FFFC;
   assign bad_tgt   = 1'b0;
`endif

   // Flush wins over a same-cycle pop; a full buffer may still take a word when it is popped.
   assign pop  = !empty && inst_ready && !redir_go;
   assign push = (state_q == FETCH) && !st_valid && !redir_go && !err_q && (!full || pop);

   always_comb begin
      state_d        = state_q;
      pc_d           = pc_q;
      wr_ptr_d       = wr_ptr_q;
      rd_ptr_d       = rd_ptr_q;
      err_d          = err_q;
      redir_pend_d   = (state_q == STORE) && redirect_valid;
      redir_pc_d     = redirect_valid ? redirect_pc : redir_pc_q;
      mem_address    = pc_q;
      mem_data_in    = '0;
      mem_read_write = 1'b0;
      st_ready       = 1'b0;

      case (state_q)
         FETCH: begin
            if (st_valid)         state_d = STORE;
            else if (full && !pop) state_d = STALL;
         end
         STALL: begin
            if (st_valid) state_d = STORE;
            else if (pop) state_d = FETCH;
         end
         STORE: begin
            mem_address    = st_addr;
            mem_data_in    = st_data;
            mem_read_write = 1'b1;
            st_ready       = 1'b1;
            state_d        = err_q ? HALT : FETCH;
         end
         HALT: begin
            if (st_valid) state_d = STORE;
         end
         default: state_d = FETCH;
      endcase

      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
         pc_d     = pc_q + 32'd4;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;

      if (redir_go) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         if (bad_tgt) begin
            err_d   = 1'b1;
            state_d = st_valid ? STORE : HALT;
         end else begin
            pc_d    = redir_tgt;
            state_d = st_valid ? STORE : FETCH;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= FETCH;
         pc_q         <= STARTING_ADDR;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         redir_pend_q <= 1'b0;
         redir_pc_q   <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         redir_pend_q <= redir_pend_d;
         redir_pc_q   <= redir_pc_d;
         err_q        <= err_d;
      end
   end

   always_ff @(posedge clock) begin
      if (push) begin
         fifo_data_q[wr_ptr_q[PW-1:0]] <= mem_data_out;
         fifo_pc_q[wr_ptr_q[PW-1:0]]   <= pc_q;
      end
   end
endmodule

// File: tb/tb_fetch_store_initiator.sv
// tb/tb_fetch_store_initiator.sv - scoreboard bench for fetch_store_initiator
module tb_fetch_store_initiator;
   logic        clock = 1'b0;
   logic        reset_n;
   logic [31:0] mem_address, mem_data_in, mem_data_out;
   logic        mem_read_write;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        st_valid, st_ready;
   logic [31:0] st_addr, st_data;
   logic        inst_valid, inst_ready;
   logic [31:0] inst_data, inst_pc;
   logic        misalign_err;

   int tests_run = 0;
   int tests_failed = 0;
   logic [63:0] sb [$];

   logic [31:0] mem [1024];
   logic        mem_init_q = 1'b0;

   fetch_store_initiator dut (
      .clock(clock), .reset_n(reset_n),
      .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
      .mem_read_write(mem_read_write),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc),
      .misalign_err(misalign_err)
   );

   always #5 clock = ~clock;

   // Memory window 0x01000000..0x01000FFF; untouched words read as 0xC0DE0000 | word index.
   always @(posedge clock) begin
      if (!mem_init_q) begin
         for (int i = 0; i < 1024; i++) mem[i] <= 32'hC0DE_0000 | i;
         mem[0] <= 32'h0000_0013;
         mem[1] <= 32'h0010_0093;
         mem_init_q <= 1'b1;
      end else if (mem_read_write && mem_address[31:12] == 20'h01000) begin
         mem[mem_address[11:2]] <= mem_data_in;
      end
   end

   always_comb begin
      if (mem_address[31:12] == 20'h01000) mem_data_out = mem[mem_address[11:2]];
      else                                 mem_data_out = 32'hFFFF_FFFF;
   end

   function automatic logic [31:0] exp_word(input logic [31:0] addr);
      if (addr == 32'h0100_0000) return 32'h0000_0013;
      if (addr == 32'h0100_0004) return 32'h0010_0093;
      return 32'hC0DE_0000 | ((addr - 32'h0100_0000) >> 2);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic expect_inst(input logic [31:0] pc, input logic [31:0] data);
      sb.push_back({pc, data});
   endtask

   task automatic expect_seq(input logic [31:0] pc, input int n);
      for (int i = 0; i < n; i++) expect_inst(pc + 32'(4 * i), exp_word(pc + 32'(4 * i)));
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Monitor: every accepted instruction must match the next queued expectation.
   always @(negedge clock) begin
      if (reset_n && inst_valid && inst_ready && !redirect_valid) begin
         if (sb.size() == 0) begin
            chk("unexpected_inst_pc", inst_pc, 32'hFFFF_FFFF);
         end else begin
            logic [63:0] e;
            e = sb.pop_front();
            chk("inst_pc", inst_pc, e[63:32]);
            chk("inst_data", inst_data, e[31:0]);
         end
      end
   end

   task automatic do_reset();
      reset_n = 1'b0;
      redirect_valid = 1'b0; redirect_pc = '0;
      st_valid = 1'b0; st_addr = '0; st_data = '0;
      inst_ready = 1'b0;
      sb.delete();
      tick(); tick();
      chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
      chk("rst_st_ready", {31'd0, st_ready}, 32'd0);
      chk("rst_rw", {31'd0, mem_read_write}, 32'd0);
      chk("rst_data_in", mem_data_in, 32'd0);
      chk("rst_misalign", {31'd0, misalign_err}, 32'd0);
      chk("rst_addr", mem_address, 32'h0100_0000);
      reset_n = 1'b1;
   endtask

   task automatic sb_drained(input string name);
      chk(name, sb.size(), 32'd0);
   endtask

   initial begin
      // Streaming fetch with decode always ready.
      do_reset();
      inst_ready = 1'b1;
      expect_seq(32'h0100_0000, 5);
      repeat (6) tick();
      inst_ready = 1'b0;
      sb_drained("stream_drained");

      // Decode stalled for 10 cycles: buffer fills, address holds.
      do_reset();
      repeat (10) tick();
      chk("stall_addr", mem_address, 32'h0100_0010);
      chk("stall_head_pc", inst_pc, 32'h0100_0000);
      expect_seq(32'h0100_0000, 8);
      inst_ready = 1'b1;
      tick();
      chk("stall_addr_after_pop", mem_address, 32'h0100_0010);
      repeat (7) tick();
      inst_ready = 1'b0;
      sb_drained("stall_drained");

      // Full buffer popped while in FETCH: push and pop together.
      do_reset();
      repeat (4) tick();
      expect_seq(32'h0100_0000, 4);
      inst_ready = 1'b1;
      repeat (4) tick();
      inst_ready = 1'b0;
      chk("full_pushpop_addr", mem_address, 32'h0100_0020);
      sb_drained("full_drained");

      // Back-to-back stores with a fetch cycle between them, then read back.
      do_reset();
      tick();
      st_valid = 1'b1; st_addr = 32'h0100_0100; st_data = 32'hDEAD_BEEF;
      tick();
      chk("st_rw", {31'd0, mem_read_write}, 32'd1);
      chk("st_ready", {31'd0, st_ready}, 32'd1);
      chk("st_addr", mem_address, 32'h0100_0100);
      chk("st_data", mem_data_in, 32'hDEAD_BEEF);
      tick();
      chk("st_gap_rw", {31'd0, mem_read_write}, 32'd0);
      chk("st_gap_ready", {31'd0, st_ready}, 32'd0);
      tick();
      chk("st2_rw", {31'd0, mem_read_write}, 32'd1);
      st_valid = 1'b0;
      tick();
      chk("st_done_rw", {31'd0, mem_read_write}, 32'd0);
      chk("st_done_data", mem_data_in, 32'd0);
      redirect_valid = 1'b1; redirect_pc = 32'h0100_0100; inst_ready = 1'b1;
      expect_inst(32'h0100_0100, 32'hDEAD_BEEF);
      expect_inst(32'h0100_0104, exp_word(32'h0100_0104));
      tick();
      redirect_valid = 1'b0;
      repeat (3) tick();
      inst_ready = 1'b0;
      sb_drained("readback_drained");

      // Redirect flushes a buffer holding three entries.
      do_reset();
      repeat (3) tick();
      chk("pre_redir_valid", {31'd0, inst_valid}, 32'd1);
      redirect_valid = 1'b1; redirect_pc = 32'h0100_0040;
      tick();
      redirect_valid = 1'b0;
      chk("redir_flush_valid", {31'd0, inst_valid}, 32'd0);
      expect_seq(32'h0100_0040, 2);
      inst_ready = 1'b1;
      repeat (3) tick();
      inst_ready = 1'b0;
      sb_drained("redir_drained");

      // Misaligned redirect target.
      do_reset();
      repeat (2) tick();
      redirect_valid = 1'b1; redirect_pc = 32'h0100_0042;
      tick();
      redirect_valid = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      inst_ready = 1'b1;
      repeat (4) tick();
      chk("misalign_err", {31'd0, misalign_err}, 32'd1);
      chk("halt_no_valid", {31'd0, inst_valid}, 32'd0);
      inst_ready = 1'b0;
`else
      expect_seq(32'h0100_0040, 1);
      inst_ready = 1'b1;
      repeat (2) tick();
      inst_ready = 1'b0;
      chk("misalign_tied", {31'd0, misalign_err}, 32'd0);
`endif
      sb_drained("misalign_drained");

      // Reset asserted in the middle of a store.
      do_reset();
      tick();
      st_valid = 1'b1; st_addr = 32'h0100_0200; st_data = 32'h1234_5678;
      tick();
      chk("mid_st_rw", {31'd0, mem_read_write}, 32'd1);
      #2 reset_n = 1'b0;
      #1 chk("async_rw_clear", {31'd0, mem_read_write}, 32'd0);
      st_valid = 1'b0;
      tick(); tick();
      chk("store_aborted", mem[128], 32'hC0DE_0080);
      reset_n = 1'b1;
      expect_seq(32'h0100_0000, 2);
      inst_ready = 1'b1;
      repeat (3) tick();
      inst_ready = 1'b0;
      sb_drained("restart_drained");

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
